l2_arbiter: RTL and testbench

Two-requester arbiter that shares the single L2 memory port between the L1 instruction cache and the data-side path (L1 data cache plus victim cache). It latches one request at a time, drives the L2 port from registers, returns the L2 response to the granted requester, and alternates priority round-robin on simultaneous requests. It sits between the L1/victim cache controllers and the L2 cache.

---
 rtl/l2_arbiter.sv | 96 +++++++++
 tb/tb_l2_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the I-side and D-side requesters.
// One request is latched at a time; simultaneous requests alternate round-robin.
module l2_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_address,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic [LINE_WIDTH-1:0] l2_rdata,
   input  logic                  l2_resp,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_e;

   state_e                state_q, state_d;
   logic                  last_d_q, last_d_d;   // 1: D side won the last grant
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  req_i, req_d, win_i;

   assign req_i = i_read;
   assign req_d = d_read | d_write;
   // I wins when it is alone or when D had the previous grant
   assign win_i = req_i & (~req_d | last_d_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      case (state_q)
         IDLE: begin
            if (win_i) begin
               state_d  = GRANT_I;
               last_d_d = 1'b0;
               wr_d     = 1'b0;
               addr_d   = i_address;
            end else if (req_d) begin
               state_d  = GRANT_D;
               last_d_d = 1'b1;
               wr_d     = d_write;
               addr_d   = d_address;
               wdata_d  = d_wdata;
            end
         end
         GRANT_I: if (l2_resp) state_d = RELEASE;
         GRANT_D: if (l2_resp) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign l2_read    = (state_q == GRANT_I) | ((state_q == GRANT_D) & ~wr_q);
   assign l2_write   = (state_q == GRANT_D) & wr_q;
   assign l2_address = addr_q;
   assign l2_wdata   = wdata_q;
   assign i_resp     = (state_q == GRANT_I) & l2_resp;
   assign d_resp     = (state_q == GRANT_D) & l2_resp;
   assign i_rdata    = l2_rdata;
   assign d_rdata    = l2_rdata;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: vector tables, directed corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_l2_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_read, i_resp, d_read, d_write, d_resp;
   logic         l2_read, l2_write, l2_resp, busy;
   logic [31:0]  i_address, d_address, l2_address;
   logic [255:0] i_rdata, d_rdata, d_wdata, l2_wdata, l2_rdata;

   int nvec = 0;
   int nmis = 0;

   l2_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
      .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         ir, dr, dw;
      logic [31:0]  ia, da;
      logic [255:0] dwd;
      logic         resp;
      logic [255:0] rdata;
      logic         e_rd, e_wr, e_ir, e_dr, e_busy;
      logic [31:0]  e_addr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
      i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      #1;
      chk("rst.l2_read", l2_read, 0);
      chk("rst.l2_write", l2_write, 0);
      chk("rst.busy", busy, 0);
      chk("rst.l2_address", l2_address, 0);
      chk("rst.l2_wdata", l2_wdata, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic add(input logic ir, dr, dw, input logic [31:0] ia, da,
                      input logic [255:0] dwd, input logic resp, input logic [255:0] rdata,
                      input logic e_rd, e_wr, e_ir, e_dr, e_busy, input logic [31:0] e_addr);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.dwd = dwd;
      v.resp = resp; v.rdata = rdata;
      v.e_rd = e_rd; v.e_wr = e_wr; v.e_ir = e_ir; v.e_dr = e_dr; v.e_busy = e_busy;
      v.e_addr = e_addr;
      tbl.push_back(v);
   endtask

   task automatic run_table(input string tag);
      for (int n = 0; n < tbl.size(); n++) begin
         i_read = tbl[n].ir; d_read = tbl[n].dr; d_write = tbl[n].dw;
         i_address = tbl[n].ia; d_address = tbl[n].da; d_wdata = tbl[n].dwd;
         l2_resp = tbl[n].resp; l2_rdata = tbl[n].rdata;
         #1;
         chk($sformatf("%s[%0d].l2_read", tag, n), l2_read, tbl[n].e_rd);
         chk($sformatf("%s[%0d].l2_write", tag, n), l2_write, tbl[n].e_wr);
         chk($sformatf("%s[%0d].i_resp", tag, n), i_resp, tbl[n].e_ir);
         chk($sformatf("%s[%0d].d_resp", tag, n), d_resp, tbl[n].e_dr);
         chk($sformatf("%s[%0d].busy", tag, n), busy, tbl[n].e_busy);
         chk($sformatf("%s[%0d].l2_address", tag, n), l2_address, tbl[n].e_addr);
         chk($sformatf("%s[%0d].i_rdata", tag, n), i_rdata, tbl[n].rdata);
         chk($sformatf("%s[%0d].d_rdata", tag, n), d_rdata, tbl[n].rdata);
         step();
      end
      tbl.delete();
   endtask

   function automatic logic [255:0] rnd_line();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference model: who owns the port, whether the post-completion gap is pending,
   // who won last, and what was captured at grant time.
   int           m_owner;   // 0 none, 1 I, 2 D
   bit           m_gap, m_last_d, m_wr;
   logic [31:0]  m_addr;
   logic [255:0] m_wd;

   logic [255:0] A5, L1234, Z;

   initial begin
      A5 = {32{8'hA5}};
      L1234 = {16{16'h1234}};
      Z = '0;
      rst_n = 1'b1;
      idle_inputs();
      #3;
      do_reset();
      step();

      // I read alone, L2 answers on the third grant cycle
      add(1,0,0, 32'h1040,0, Z, 0, Z,  0,0,0,0,0, 32'h0);
      add(1,0,0, 32'h1040,0, Z, 0, Z,  1,0,0,0,1, 32'h1040);
      add(1,0,0, 32'h1040,0, Z, 0, Z,  1,0,0,0,1, 32'h1040);
      add(1,0,0, 32'h1040,0, Z, 1, A5, 1,0,1,0,1, 32'h1040);
      add(0,0,0, 32'h1040,0, Z, 0, Z,  0,0,0,0,1, 32'h1040);
      add(0,0,0, 32'h1040,0, Z, 0, Z,  0,0,0,0,0, 32'h1040);
      run_table("iread");

      // Three ties with both requests held: I, D, I
      do_reset();
      add(1,1,0, 32'h100,32'h200, Z, 0, Z,  0,0,0,0,0, 32'h0);
      add(1,1,0, 32'h100,32'h200, Z, 1, A5, 1,0,1,0,1, 32'h100);
      add(1,1,0, 32'h100,32'h200, Z, 0, Z,  0,0,0,0,1, 32'h100);
      add(1,1,0, 32'h100,32'h200, Z, 0, Z,  0,0,0,0,0, 32'h100);
      add(1,1,0, 32'h100,32'h200, Z, 1, A5, 1,0,0,1,1, 32'h200);
      add(1,1,0, 32'h100,32'h200, Z, 0, Z,  0,0,0,0,1, 32'h200);
      add(1,1,0, 32'h100,32'h200, Z, 0, Z,  0,0,0,0,0, 32'h200);
      add(1,1,0, 32'h100,32'h200, Z, 1, A5, 1,0,1,0,1, 32'h100);
      run_table("tie");

      // D write; requester data changes after grant
      do_reset();
      d_write = 1; d_address = 32'h2000; d_wdata = L1234;
      step();
      d_wdata = '0; #1;
      chk("dw.l2_write", l2_write, 1);
      chk("dw.l2_read", l2_read, 0);
      chk("dw.l2_wdata", l2_wdata, L1234);
      chk("dw.d_resp_early", d_resp, 0);
      step();
      l2_resp = 1; #1;
      chk("dw.d_resp", d_resp, 1);
      chk("dw.i_resp", i_resp, 0);
      chk("dw.l2_wdata_hold", l2_wdata, L1234);
      step();
      d_write = 0; l2_resp = 0; #1;
      chk("dw.release_strobe", l2_write, 0);
      chk("dw.release_busy", busy, 1);
      step();
      // Read and write together: write wins
      d_read = 1; d_write = 1; d_address = 32'h3000; #1;
      chk("rw.idle_busy", busy, 0);
      step();
      chk("rw.l2_write", l2_write, 1);
      chk("rw.l2_read", l2_read, 0);
      chk("rw.addr", l2_address, 32'h3000);
      l2_resp = 1;
      step();
      d_read = 0; d_write = 0; l2_resp = 0;
      step();

      // D request arrives during an I grant
      do_reset();
      i_read = 1; i_address = 32'h4000;
      step();
      d_read = 1; d_address = 32'h5000; #1;
      chk("late.l2_read_i", l2_read, 1);
      chk("late.d_resp0", d_resp, 0);
      step();
      l2_resp = 1; #1;
      chk("late.i_resp", i_resp, 1);
      chk("late.d_resp1", d_resp, 0);
      step();
      i_read = 0; l2_resp = 0; #1;
      chk("late.release", l2_read, 0);
      chk("late.release_busy", busy, 1);
      step();
      chk("late.idle_busy", busy, 0);
      step();
      chk("late.grant_d", l2_read, 1);
      chk("late.grant_d_addr", l2_address, 32'h5000);
      l2_resp = 1; #1;
      chk("late.d_resp", d_resp, 1);
      step();
      d_read = 0; l2_resp = 0;
      step();

      // Reset aborts a D write in flight; first tie afterwards goes to I
      do_reset();
      d_write = 1; d_address = 32'h6000; d_wdata = L1234;
      step();
      chk("abort.l2_write", l2_write, 1);
      rst_n = 0; #1;
      chk("abort.l2_write_drop", l2_write, 0);
      chk("abort.busy", busy, 0);
      chk("abort.addr", l2_address, 0);
      chk("abort.d_resp", d_resp, 0);
      step();
      #2;
      rst_n = 1;
      i_read = 1; i_address = 32'h7000;
      step();
      chk("abort.tie_i", l2_read, 1);
      chk("abort.tie_w", l2_write, 0);
      chk("abort.tie_addr", l2_address, 32'h7000);
      l2_resp = 1;
      step();
      i_read = 0; d_write = 0; l2_resp = 0;
      step();

      // Randomized run against the reference model
      do_reset();
      m_owner = 0; m_gap = 0; m_last_d = 1; m_wr = 0; m_addr = '0; m_wd = '0;
      begin
         bit i_done = 0, d_done = 0;
         for (int c = 0; c < 600; c++) begin
            if (i_done) begin i_read = 0; i_done = 0; end
            else if (!i_read && ($urandom % 3 == 0)) begin
               i_read = 1; i_address = $urandom & 32'hFFFF_FFE0;
            end
            if (d_done) begin d_read = 0; d_write = 0; d_done = 0; end
            else if (!(d_read || d_write) && ($urandom % 3 == 0)) begin
               int op;
               op = $urandom % 3;
               d_read = (op != 1); d_write = (op != 0);
            end
            d_address = $urandom & 32'hFFFF_FFE0;
            d_wdata = rnd_line();
            l2_resp = ($urandom % 3 == 0);
            l2_rdata = rnd_line();
            #1;
            chk("rnd.l2_read", l2_read, (m_owner == 1) || (m_owner == 2 && !m_wr));
            chk("rnd.l2_write", l2_write, (m_owner == 2) && m_wr);
            chk("rnd.i_resp", i_resp, (m_owner == 1) && l2_resp);
            chk("rnd.d_resp", d_resp, (m_owner == 2) && l2_resp);
            chk("rnd.busy", busy, (m_owner != 0) || m_gap);
            chk("rnd.i_rdata", i_rdata, l2_rdata);
            if (m_owner != 0) chk("rnd.l2_address", l2_address, m_addr);
            if (m_owner == 2 && m_wr) chk("rnd.l2_wdata", l2_wdata, m_wd);
            if (m_owner == 1 && l2_resp) i_done = 1;
            if (m_owner == 2 && l2_resp) d_done = 1;
            // advance the model across the coming edge
            if (m_gap) m_gap = 0;
            else if (m_owner != 0) begin
               if (l2_resp) begin m_owner = 0; m_gap = 1; end
            end else begin
               bit wi, wd;
               wi = i_read; wd = d_read || d_write;
               if (wi && (!wd || m_last_d)) begin
                  m_owner = 1; m_addr = i_address; m_last_d = 0;
               end else if (wd) begin
                  m_owner = 2; m_addr = d_address; m_wd = d_wdata;
                  m_wr = d_write; m_last_d = 1;
               end
            end
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
